// File: rtl/fp_sqrt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_sqrt_pkg
//  Brief    : Shared definitions for the mantissa square / square-root blocks:
//             sequencer state encoding, default mantissa width and latency.
//  Revision : 1.0  initial release
// ============================================================================
package fp_sqrt_pkg;

    // Stored mantissa width (hidden bit excluded) of single precision.
    localparam int MANT_W_DEFAULT = 23;

    // Edges from the accepting edge until out_valid is first seen high:
    // MANT_W+1 shift-add steps, one cycle to observe done, one NORM cycle.
    localparam int LATENCY = MANT_W_DEFAULT + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/fixed_point_square_shift_add_mul.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mul
//  Brief    : Sequential radix-2 shift-add squarer. Captures X on start_i,
//             then adds the left-shifting multiplicand into a full-width
//             accumulator once per cycle, LSB-first over X, for MANT_W+1
//             cycles. done_o stays high from the last step until the next
//             start. Only the product bits the normalizer can use are exported.
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_mul
    import fp_sqrt_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [MANT_W:0]     x_i,
    output logic                done_o,
    output logic [MANT_W+1:0]   prod_hi_o
);

    localparam int c_XW    = MANT_W + 1;
    localparam int c_PW    = 2 * c_XW;
    localparam int c_CNT_W = $clog2(c_XW);
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(MANT_W);

    logic [c_XW-1:0]    x_q;       // multiplier, consumed LSB-first
    logic [c_PW-1:0]    mcand_q;   // multiplicand, shifted left each step
    logic [c_PW-1:0]    acc_q;
    logic [c_PW-1:0]    acc_d;
    logic [c_CNT_W-1:0] cnt_q;
    logic               busy_q;
    logic               done_q;

    // Conditional add for the current multiplier bit; full width, no truncation.
    always_comb begin
        acc_d = acc_q;
        if (x_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    // Capture on start, then one shift-add step per cycle until the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (start_i) begin
            x_q     <= x_i;
            mcand_q <= c_PW'(x_i);
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else if (busy_q) begin
            acc_q   <= acc_d;
            x_q     <= x_q >> 1;
            mcand_q <= mcand_q << 1;
            cnt_q   <= cnt_q + c_CNT_W'(1);
            if (cnt_q == c_LAST_STEP) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done_o    = done_q;
    assign prod_hi_o = acc_q[c_PW-1:MANT_W];

endmodule
`default_nettype wire

// File: rtl/fixed_point_square.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_point_square
//  Brief    : Squares a normalized mantissa 1.Y using a sequential shift-add
//             multiplier, then normalizes the Q2 product back to Q1.MANT_W,
//             flagging when the exponent must be incremented. Truncates.
//  Revision : 1.0  initial release
// ============================================================================
module fixed_point_square
    import fp_sqrt_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MANT_W-1:0] Y,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [MANT_W:0]   result,
    output logic              exp_inc,
    output logic              out_valid,
    input  logic              out_ready
);

    fsm_state_t        state_q;
    logic              mul_start;
    logic              mul_done;
    logic [MANT_W+1:0] prod_hi;
    logic [MANT_W:0]   result_q;
    logic [MANT_W:0]   result_d;
    logic              exp_inc_q;
    logic              exp_inc_d;
    logic              out_valid_q;

    // Ready is a pure state decode so it never depends on out_ready.
    assign in_ready  = (state_q == IDLE);
    assign mul_start = in_valid && in_ready;

    shift_add_mul #(
        .MANT_W    (MANT_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .x_i       ({1'b1, Y}),
        .done_o    (mul_done),
        .prod_hi_o (prod_hi)
    );

    // Normalize: a set top bit means the square reached [2,4).
    always_comb begin
        exp_inc_d = prod_hi[MANT_W+1];
        result_d  = exp_inc_d ? prod_hi[MANT_W+1:1] : prod_hi[MANT_W:0];
    end

    // Sequencer with registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            exp_inc_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_start) begin
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    result_q    <= result_d;
                    exp_inc_q   <= exp_inc_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result    = result_q;
    assign exp_inc   = exp_inc_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_square.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fixed_point_square
//  Brief    : Self-checking bench for fixed_point_square: directed corner
//             values, back-pressure hold, mid-operation reset and random
//             mantissas against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fixed_point_square;

    localparam int MW      = 23;
    localparam int LAT_EXP = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic [MW-1:0] Y;
    logic          in_valid;
    logic          in_ready;
    logic [MW:0]   result;
    logic          exp_inc;
    logic          out_valid;
    logic          out_ready;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    fixed_point_square #(
        .MANT_W    (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Y         (Y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .exp_inc   (exp_inc),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Square of 1.y in Q2.(2*MW); >= 2.0 means shift one extra place and bump exponent.
    function automatic void ref_square(input logic [MW-1:0] y, output logic [MW:0] res, output logic ei);
        longint unsigned x;
        longint unsigned p;
        logic [63:0]     t;
        x = (64'd1 << MW) + 64'(y);
        p = x * x;
        if (p >= (64'd1 << (2 * MW + 1))) begin
            ei = 1'b1;
            t  = p >> (MW + 1);
        end else begin
            ei = 1'b0;
            t  = p >> MW;
        end
        res = t[MW:0];
    endfunction

    // sqrt(result * 2^exp_inc) must land back on 1.y within truncation error.
    task automatic check_sqrt(input logic [MW-1:0] y, input logic [MW:0] r, input logic e);
        real sq;
        real rt;
        real yv;
        real err;
        sq = real'(r) / (2.0 ** MW);
        if (e) sq = sq * 2.0;
        rt  = $sqrt(sq);
        yv  = 1.0 + real'(y) / (2.0 ** MW);
        err = rt - yv;
        if (err < 0.0) err = -err;
        check("sqrt_consistency", (err < 2.0 ** (-21)) ? 64'd1 : 64'd0, 64'd1);
    endtask

    // One full transaction; random noise on Y/in_valid/out_ready while busy,
    // then 'hold' cycles of back-pressure in DONE before consuming.
    task automatic do_op(input logic [MW-1:0] y, input int hold,
                         output logic [MW:0] res, output logic ei);
        int lat;
        bit seen;
        @(negedge clk);
        check("ready_idle", 64'(in_ready), 64'd1);
        Y         = y;
        in_valid  = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        check("ready_busy", 64'(in_ready), 64'd0);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            Y         = MW'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        check("latency", 64'(lat), 64'(LAT_EXP));
        res = result;
        ei  = exp_inc;
        for (int i = 0; i < hold; i++) begin
            Y        = MW'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("hold_result", 64'(result), 64'(res));
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("consumed_valid", 64'(out_valid), 64'd0);
        check("consumed_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [MW:0]   r;
        logic          e;
        logic [MW:0]   mr;
        logic          me;
        logic [MW-1:0] y;
        bit            seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Y         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_exp_inc", 64'(exp_inc), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Corner mantissas.
        do_op(23'h000000, 0, r, e);
        check("y0_result", 64'(r), 64'h800000);
        check("y0_exp_inc", 64'(e), 64'd0);
        do_op(23'h400000, 0, r, e);
        check("y15_result", 64'(r), 64'h900000);
        check("y15_exp_inc", 64'(e), 64'd1);
        do_op(23'h7FFFFF, 0, r, e);
        check("ymax_result", 64'(r), 64'hFFFFFE);
        check("ymax_exp_inc", 64'(e), 64'd1);
        do_op(23'h3504F3, 0, r, e);
        check("ysqrt2_exp_inc", 64'(e), 64'd0);
        check("ysqrt2_top", 64'(r[MW:MW-3]), 64'hF);

        // Back-pressure: result held for 10 cycles, then next Y accepted.
        do_op(23'h2AAAAA, 10, r, e);
        ref_square(23'h2AAAAA, mr, me);
        check("hold_op_result", 64'(r), 64'(mr));
        check("hold_op_exp_inc", 64'(e), 64'(me));
        do_op(23'h155555, 0, r, e);
        ref_square(23'h155555, mr, me);
        check("after_hold_result", 64'(r), 64'(mr));

        // Reset in the middle of the multiply aborts the operation.
        @(negedge clk);
        Y        = 23'h400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        Y        = '0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_output", 64'(seen), 64'd0);
        do_op(23'h400000, 0, r, e);
        check("post_rst_result", 64'(r), 64'h900000);
        check("post_rst_exp_inc", 64'(e), 64'd1);

        // Random mantissas against the reference model.
        for (int n = 0; n < 1000; n++) begin
            y = MW'($urandom);
            do_op(y, 0, r, e);
            ref_square(y, mr, me);
            check("rand_result", 64'(r), 64'(mr));
            check("rand_exp_inc", 64'(e), 64'(me));
            check_sqrt(y, r, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
